// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: carries EX results into MEM and returns the
// multi-cycle accumulate state (hilo/cnt) back to EX while EX is stalled.
module ex_mem_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned ALUOP_W = 8,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EX_IDX  = 3,
  parameter int unsigned MEM_IDX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [RADDR_W-1:0]    ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [1:0]            cnt_i,
  output logic                  mem_valid,
  output logic [RADDR_W-1:0]    mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [1:0]            cnt_o
);

  logic stall_ex;
  logic stall_mem;
  logic advance;
  logic bubble;
  logic stall_unused;

  // Only the EX and MEM stall bits matter; EX-go with MEM-stalled is
  // illegal and falls through to hold.
  assign stall_ex     = stall[EX_IDX];
  assign stall_mem    = stall[MEM_IDX];
  assign advance      = !stall_ex && !stall_mem;
  assign bubble       = stall_ex && !stall_mem;
  assign stall_unused = ^stall;

  // Stage payload: reset/flush clear, advance copies, bubble inserts NOP, else hold.
  always_ff @(posedge clk) begin
    if (rst || flush || bubble) begin
      mem_valid    <= 1'b0;
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_whilo    <= 1'b0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
    end else if (advance) begin
      mem_valid    <= ex_valid;
      mem_wd       <= ex_wd;
      mem_wreg     <= ex_wreg;
      mem_wdata    <= ex_wdata;
      mem_whilo    <= ex_whilo;
      mem_hi       <= ex_hi;
      mem_lo       <= ex_lo;
      mem_aluop    <= ex_aluop;
      mem_mem_addr <= ex_mem_addr;
      mem_reg2     <= ex_reg2;
    end
  end

  // Accumulate state loops back to EX only while EX is stalled; cleared otherwise.
  always_ff @(posedge clk) begin
    if (rst || flush || advance) begin
      hilo_o <= '0;
      cnt_o  <= 2'b00;
    end else begin
      hilo_o <= hilo_i;
      cnt_o  <= cnt_i;
    end
  end

endmodule
